accumulator_bank: RTL and testbench

- Parametrised accumulator with a built-in result store. Sits between the MAC array and the output buffer.
- Takes ARR_SIZE lane-wide partial sums per transfer and overwrites or accumulates them into one of DEPTH entries, using signed saturating arithmetic.
- On request, drains an entry to the output buffer as OUT_W-wide beats under a valid/ready handshake, optionally clearing it afterwards.

---
 rtl/accumulator_bank.sv | 186 ++++++++++++++++++
 tb/tb_accumulator_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_bank.sv
// accumulator_bank
//   Result store between the MAC array and the output buffer. Each transfer
//   carries ARR_SIZE signed lanes. A transfer either overwrites an entry or is
//   added into it lane by lane, and the sums saturate. A drain streams one
//   entry out as BEATS beats of OUT_W bits under valid/ready. The entry can be
//   cleared when the drain finishes.
//
// Ports
//   clk_i, rst_n_i         clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o  partial-sum transfer handshake
//   in_addr_i, in_mode_i   target entry; 0 = overwrite, 1 = accumulate
//   in_data_i              lane i at [i*DATA_W +: DATA_W]
//   drain_start_i          pulse that starts draining drain_addr_i
//   drain_clear_i          zero the entry once the last beat is accepted
//   busy_o                 drain in progress
//   out_valid_o/out_ready_i drain beat handshake
//   out_data_o, out_addr_o beat payload and {entry, beat} address
//   out_last_o             final beat of the drain
//   sat_flag_o, sat_clr_i  sticky saturation indicator and its clear
//
// FSM states
//   state   | meaning
//   S_IDLE  | accepting transfers, waiting for drain_start
//   S_DRAIN | presenting beats of the latched entry, no writes
module accumulator_bank #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int OUT_W    = 64,
  localparam int BEATS   = ARR_SIZE * DATA_W / OUT_W,
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ADDR_W-1:0]          in_addr_i,
  input  logic                       in_mode_i,
  input  logic [ARR_SIZE*DATA_W-1:0] in_data_i,
  input  logic                       drain_start_i,
  input  logic [ADDR_W-1:0]          drain_addr_i,
  input  logic                       drain_clear_i,
  output logic                       busy_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OUT_W-1:0]           out_data_o,
  output logic [ADDR_W+BEAT_W-1:0]   out_addr_o,
  output logic                       out_last_o,
  output logic                       sat_flag_o,
  input  logic                       sat_clr_i
);

  localparam int ROW_W = ARR_SIZE * DATA_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [DATA_W-1:0] LANE_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] LANE_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0]   addr_q;
  logic                clr_q;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                sat_q, sat_d;

  logic                start_now;
  logic                drain_active;
  logic                accept;
  logic                last_accept;
  logic                wr_en;
  logic [ROW_W-1:0]    cur_entry;
  logic [ROW_W-1:0]    wr_data_d;
  logic [ARR_SIZE-1:0] sat_hit;
  logic [OUT_W-1:0]    beat_data [BEATS];

  assign drain_active = (state_q == S_DRAIN);
  assign start_now    = (state_q == S_IDLE) & drain_start_i;
  assign accept       = drain_active & out_ready_i;
  assign last_accept  = accept & (beat_q == LAST_BEAT);
  assign wr_en        = in_valid_i & in_ready_o;
  assign cur_entry    = mem_q[in_addr_i];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (drain_start_i) state_d = S_DRAIN;
      S_DRAIN: if (last_accept)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // out_valid is driven from the state register, so it appears on the
  // cycle after drain_start is taken.
  always_comb begin
    in_ready_o  = (state_q == S_IDLE) & ~drain_start_i;
    busy_o      = drain_active;
    out_valid_o = drain_active;
    out_last_o  = drain_active & (beat_q == LAST_BEAT);
    out_data_o  = drain_active ? beat_data[beat_q] : '0;
    out_addr_o  = drain_active ? {addr_q, beat_q} : '0;
  end

  // Slice the latched entry into beats, with the lowest lane in the LSBs.
  // The entry cannot change during a drain, so the beats stay stable.
  always_comb begin
    for (int b = 0; b < BEATS; b++) begin
      beat_data[b] = mem_q[addr_q][b*OUT_W +: OUT_W];
    end
  end

  // Per-lane add done at DATA_W+1 bits. A mismatch between the top two
  // bits of the sum means overflow, and the top bit gives its direction.
  always_comb begin
    wr_data_d = '0;
    sat_hit   = '0;
    for (int l = 0; l < ARR_SIZE; l++) begin
      logic [DATA_W-1:0] lane_a;
      logic [DATA_W-1:0] lane_b;
      logic [DATA_W:0]   lane_sum;
      logic [DATA_W-1:0] lane_res;
      lane_a   = cur_entry[l*DATA_W +: DATA_W];
      lane_b   = in_data_i[l*DATA_W +: DATA_W];
      lane_sum = {lane_a[DATA_W-1], lane_a} + {lane_b[DATA_W-1], lane_b};
      if (!in_mode_i) begin
        lane_res = lane_b;
      end else if (lane_sum[DATA_W] != lane_sum[DATA_W-1]) begin
        lane_res   = lane_sum[DATA_W] ? LANE_MIN : LANE_MAX;
        sat_hit[l] = 1'b1;
      end else begin
        lane_res = lane_sum[DATA_W-1:0];
      end
      wr_data_d[l*DATA_W +: DATA_W] = lane_res;
    end
  end

  // A new saturation in the same cycle as sat_clr wins.
  assign sat_d = (sat_q & ~sat_clr_i) | (wr_en & (|sat_hit));

  always_comb begin
    beat_d = beat_q;
    if (start_now)        beat_d = '0;
    else if (last_accept) beat_d = '0;
    else if (accept)      beat_d = beat_q + BEAT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q <= '0;
      clr_q  <= 1'b0;
      beat_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      sat_q  <= sat_d;
      if (start_now) begin
        addr_q <= drain_addr_i;
        clr_q  <= drain_clear_i;
      end
    end
  end

  // Writes only happen in IDLE and clears only at the end of a drain,
  // so the two never occur in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[in_addr_i] <= wr_data_d;
    end else if (last_accept && clr_q) begin
      mem_q[addr_q] <= '0;
    end
  end

  assign sat_flag_o = sat_q;

endmodule

// File: tb/tb_accumulator_bank.sv
module tb_accumulator_bank;

  localparam int BEATS = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_addr = '0;
  logic         in_mode = 1'b0;
  logic [127:0] in_data = '0;
  logic         drain_start = 1'b0;
  logic [3:0]   drain_addr = '0;
  logic         drain_clear = 1'b0;
  logic         busy;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic [4:0]   out_addr;
  logic         out_last;
  logic         sat_flag;
  logic         sat_clr = 1'b0;

  accumulator_bank dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
    .in_mode_i(in_mode), .in_data_i(in_data),
    .drain_start_i(drain_start), .drain_addr_i(drain_addr), .drain_clear_i(drain_clear),
    .busy_o(busy), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_addr_o(out_addr), .out_last_o(out_last),
    .sat_flag_o(sat_flag), .sat_clr_i(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  addr;
    logic        last;
  } beat_t;

  beat_t        sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           mdl [16][4];
  bit           model_sat = 0;
  logic [3:0]   coll_addr;
  logic [127:0] coll_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic int rv();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 2000)) - 1000;
  endfunction

  // Reference: plain integer arithmetic with explicit clamping.
  task automatic model_apply(input int a, input bit mode, input logic [127:0] d);
    for (int l = 0; l < 4; l++) begin
      int b;
      longint s;
      b = int'(d[l*32 +: 32]);
      s = mode ? longint'(mdl[a][l]) + longint'(b) : longint'(b);
      if (s > 64'sd2147483647) begin s = 64'sd2147483647; model_sat = 1; end
      if (s < -64'sd2147483648) begin s = -64'sd2147483648; model_sat = 1; end
      mdl[a][l] = int'(s);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++)
      for (int l = 0; l < 4; l++) mdl[a][l] = 0;
    model_sat = 0;
  endtask

  task automatic push_drain(input int a);
    beat_t e;
    logic [3:0] a4;
    a4 = a[3:0];
    for (int k = 0; k < BEATS; k++) begin
      e.data = {mdl[a][2*k+1], mdl[a][2*k]};
      e.addr = {a4, k[0]};
      e.last = (k == BEATS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wr(input int a, input bit mode, input logic [127:0] d);
    @(posedge clk); #1;
    check("sat_flag", {63'd0, sat_flag}, {63'd0, model_sat});
    in_valid = 1; in_addr = a[3:0]; in_mode = mode; in_data = d;
    #1 check("in_ready", {63'd0, in_ready}, 64'd1);
    model_apply(a, mode, d);
  endtask

  task automatic wr_end();
    @(posedge clk); #1;
    in_valid = 0;
    check("sat_flag_end", {63'd0, sat_flag}, {63'd0, model_sat});
  endtask

  task automatic drain(input int a, input bit clr, input int stall, input bit rnd_bp, input bit collide);
    int n;
    @(posedge clk); #1;
    drain_start = 1; drain_addr = a[3:0]; drain_clear = clr; out_ready = 0;
    if (collide) begin
      in_valid = 1; in_addr = coll_addr; in_mode = 1; in_data = coll_data;
      #1 check("collide_in_ready", {63'd0, in_ready}, 64'd0);
    end
    push_drain(a);
    @(posedge clk); #1;
    drain_start = 0; drain_clear = 0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("valid_after_start", {63'd0, out_valid}, 64'd1);
    n = 0;
    while (busy && n < 100) begin
      if (collide) check("in_ready_in_drain", {63'd0, in_ready}, 64'd0);
      out_ready = (n < stall) ? 1'b0 : (rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      @(posedge clk); #1;
      n++;
    end
    out_ready = 0;
    check("drain_done", {63'd0, busy}, 64'd0);
    if (!rnd_bp) check("drain_cycles", 64'(n), 64'(BEATS + stall));
    check("beats_outstanding", 64'(sb.size()), 64'd0);
    if (clr) for (int l = 0; l < 4; l++) mdl[a][l] = 0;
    if (collide) begin
      check("in_ready_after_drain", {63'd0, in_ready}, 64'd1);
      model_apply(int'(coll_addr), 1, coll_data);
      @(posedge clk); #1;
      in_valid = 0;
    end
  endtask

  // Monitor: pops the scoreboard on each accepted beat and checks that a
  // stalled beat is held unchanged.
  bit          stalled = 0;
  logic [63:0] held_data;
  logic [4:0]  held_addr;
  logic        held_last;
  beat_t       exp_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled && out_valid) begin
        check("hold_data", out_data, held_data);
        check("hold_addr", {59'd0, out_addr}, {59'd0, held_addr});
        check("hold_last", {63'd0, out_last}, {63'd0, held_last});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got beat at addr %0h, expected none", out_addr);
        end else begin
          exp_b = sb.pop_front();
          check("beat_data", out_data, exp_b.data);
          check("beat_addr", {59'd0, out_addr}, {59'd0, exp_b.addr});
          check("beat_last", {63'd0, out_last}, {63'd0, exp_b.last});
        end
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_addr = out_addr;
      held_last = out_last;
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sat", {63'd0, sat_flag}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_addr", {59'd0, out_addr}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    rst_n = 1;
    #1 check("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // overwrite then back-to-back accumulate
    wr(3, 0, pk(1, 2, 3, 4));
    wr(3, 1, pk(10, 20, 30, 40));
    wr_end();
    drain(3, 0, 0, 0, 0);

    // saturation in both directions
    wr(0, 0, pk(32'h7FFFFFF0, 32'h80000010, 0, 0));
    wr(0, 1, pk(32'h20, 0, 0, 0));
    wr(0, 1, pk(0, -32'h40, 0, 0));
    wr_end();
    repeat (3) @(posedge clk);
    #1 check("sat_sticky", {63'd0, sat_flag}, 64'd1);
    drain(0, 0, 0, 0, 0);
    @(posedge clk); #1 sat_clr = 1;
    @(posedge clk); #1 sat_clr = 0;
    model_sat = 0;
    check("sat_cleared", {63'd0, sat_flag}, 64'd0);
    // clear and a new saturation in the same cycle: set wins
    wr(0, 1, pk(1, 0, 0, 0));
    sat_clr = 1;
    wr_end();
    sat_clr = 0;
    @(posedge clk); #1 sat_clr = 1;
    @(posedge clk); #1 sat_clr = 0;
    model_sat = 0;

    // backpressure on beat 0
    drain(3, 0, 3, 0, 0);

    // drain with clear, then accumulate into the cleared entry
    wr(5, 0, pk(100, -200, 300, -400));
    wr_end();
    drain(5, 1, 0, 0, 0);
    wr(5, 1, pk(1, 1, 1, 1));
    wr_end();
    drain(5, 0, 0, 0, 0);

    // collision: drain wins, write lands afterwards
    coll_addr = 4'd3;
    coll_data = pk(5, 6, 7, 8);
    drain(3, 0, 0, 0, 1);
    drain(3, 0, 0, 0, 0);

    // randomized traffic
    repeat (60) begin
      if ($urandom_range(0, 3) != 0) begin
        repeat ($urandom_range(1, 4))
          wr(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), pk(rv(), rv(), rv(), rv()));
        wr_end();
      end else begin
        drain(int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, 0, 1, 0);
      end
    end

    // reset in the middle of a drain
    wr(2, 0, pk(7, 8, 9, 10));
    wr_end();
    @(posedge clk); #1;
    drain_start = 1; drain_addr = 4'd2; out_ready = 1;
    push_drain(2);
    @(posedge clk); #1 drain_start = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_out_data", out_data, 64'd0);
    check("rstmid_sat", {63'd0, sat_flag}, 64'd0);
    check("rstmid_beats_seen", 64'(sb.size()), 64'(BEATS - 1));
    sb.delete();
    model_reset();
    out_ready = 0;
    @(posedge clk); #1 rst_n = 1;
    for (int a = 0; a < 16; a++) drain(a, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
